// File: rtl/bip_sequencer.sv
// bip_sequencer: fetch/decode/execute control FSM for a small accumulator CPU
// with ROM/RAM handshakes, acknowledge timeouts and a sticky trap state.
module bip_sequencer #(
   parameter int unsigned TIMEOUT = 15
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        start_i,
   input  logic        stop_i,
   output logic        rom_req_o,
   input  logic        rom_ack_i,
   input  logic [15:0] instr_i,
   output logic        ram_req_o,
   output logic        ram_we_o,
   input  logic        ram_ack_i,
   output logic [10:0] pc_o,
   output logic [10:0] operand_o,
   output logic [1:0]  sela_o,
   output logic        selb_o,
   output logic        op_o,
   output logic        wracc_o,
   output logic        busy_o,
   output logic        err_o,
   output logic [1:0]  err_code_o,
   output logic [15:0] retired_o
);
   typedef enum logic [2:0] {IDLE, FETCH, DECODE, MEM, EXEC, TRAP} state_t;
   localparam logic [4:0] NOP = 5'd0, STO = 5'd1, LD = 5'd2, LDI = 5'd3;
   localparam logic [4:0] ADD = 5'd4, ADDI = 5'd5, SUB = 5'd6, SUBI = 5'd7;
   state_t      r_state;
   logic [4:0]  r_opc;
   logic [7:0]  r_wait;
   logic [10:0] r_pc, r_operand;
   logic [15:0] r_retired;
   logic        r_rom_req, r_ram_req, r_ram_we, r_busy, r_err;
   logic        r_selb, r_op, r_wracc;
   logic [1:0]  r_sela, r_err_code;
   logic        w_mem_op, w_timeout, w_selb, w_op, w_wracc;
   logic [1:0]  w_sela;
   assign w_mem_op  = (r_opc == STO) || (r_opc == LD) || (r_opc == ADD) || (r_opc == SUB);
   assign w_timeout = r_wait == 8'(TIMEOUT);
   // Datapath controls for the latched opcode, loaded on entry to EXEC
   assign w_wracc = !((r_opc == NOP) || (r_opc == STO));
   assign w_sela  = (r_opc == LDI) ? 2'b01 : (r_opc >= ADD) ? 2'b10 : 2'b00;
   assign w_selb  = (r_opc == LDI) || (r_opc == ADDI) || (r_opc == SUBI);
   assign w_op    = (r_opc == ADD) || (r_opc == ADDI);
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state    <= IDLE;
         r_opc      <= '0;
         r_wait     <= '0;
         r_pc       <= '0;
         r_operand  <= '0;
         r_retired  <= '0;
         r_rom_req  <= 1'b0;
         r_ram_req  <= 1'b0;
         r_ram_we   <= 1'b0;
         r_busy     <= 1'b0;
         r_err      <= 1'b0;
         r_err_code <= 2'b00;
         r_sela     <= 2'b00;
         r_selb     <= 1'b0;
         r_op       <= 1'b0;
         r_wracc    <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (start_i) begin
                  r_state   <= FETCH;
                  r_rom_req <= 1'b1;
                  r_busy    <= 1'b1;
                  r_wait    <= '0;
               end
            end
            FETCH: begin
               if (rom_ack_i) begin
                  r_opc     <= instr_i[15:11];
                  r_operand <= instr_i[10:0];
                  r_rom_req <= 1'b0;
                  r_state   <= DECODE;
               end else if (w_timeout) begin
                  r_rom_req  <= 1'b0;
                  r_busy     <= 1'b0;
                  r_err      <= 1'b1;
                  r_err_code <= 2'b10;
                  r_state    <= TRAP;
               end else begin
                  r_wait <= r_wait + 8'd1;
               end
            end
            DECODE: begin
               if (r_opc > SUBI) begin
                  r_busy     <= 1'b0;
                  r_err      <= 1'b1;
                  r_err_code <= 2'b01;
                  r_state    <= TRAP;
               end else if (w_mem_op) begin
                  r_ram_req <= 1'b1;
                  r_ram_we  <= r_opc == STO;
                  r_wait    <= '0;
                  r_state   <= MEM;
               end else begin
                  r_sela  <= w_sela;
                  r_selb  <= w_selb;
                  r_op    <= w_op;
                  r_wracc <= w_wracc;
                  r_state <= EXEC;
               end
            end
            MEM: begin
               if (ram_ack_i) begin
                  r_ram_req <= 1'b0;
                  r_ram_we  <= 1'b0;
                  r_sela    <= w_sela;
                  r_selb    <= w_selb;
                  r_op      <= w_op;
                  r_wracc   <= w_wracc;
                  r_state   <= EXEC;
               end else if (w_timeout) begin
                  r_ram_req  <= 1'b0;
                  r_ram_we   <= 1'b0;
                  r_busy     <= 1'b0;
                  r_err      <= 1'b1;
                  r_err_code <= 2'b11;
                  r_state    <= TRAP;
               end else begin
                  r_wait <= r_wait + 8'd1;
               end
            end
            EXEC: begin
               r_sela    <= 2'b00;
               r_selb    <= 1'b0;
               r_op      <= 1'b0;
               r_wracc   <= 1'b0;
               r_pc      <= r_pc + 11'd1;
               r_retired <= (&r_retired) ? r_retired : r_retired + 16'd1;
               if (stop_i) begin
                  r_busy  <= 1'b0;
                  r_state <= IDLE;
               end else begin
                  r_rom_req <= 1'b1;
                  r_wait    <= '0;
                  r_state   <= FETCH;
               end
            end
            TRAP: r_state <= TRAP;
            default: r_state <= IDLE;
         endcase
      end
   end
   assign rom_req_o  = r_rom_req;
   assign ram_req_o  = r_ram_req;
   assign ram_we_o   = r_ram_we;
   assign pc_o       = r_pc;
   assign operand_o  = r_operand;
   assign sela_o     = r_sela;
   assign selb_o     = r_selb;
   assign op_o       = r_op;
   assign wracc_o    = r_wracc;
   assign busy_o     = r_busy;
   assign err_o      = r_err;
   assign err_code_o = r_err_code;
   assign retired_o  = r_retired;
endmodule
